pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 28, giving the width of the period/high-time counters and outputs; it matches the 28-bit Period/Decode PIO words.
REQ-002 SHALL have parameter TIMEOUT, default 28'd50_000_000, giving the maximum cycles between rising edges before the input is declared stuck.
REQ-003 SHALL have port CLK, input, 1, system clock; all logic is in this single clock domain.
REQ-004 SHALL have port RST_N, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port EN, input, 1, measurement enable.
REQ-006 SHALL have port PWM_IN, input, 1, external PWM signal, asynchronous to CLK.
REQ-007 SHALL have port Period, output, CNT_W, last measured period in CLK cycles (rising edge to rising edge).
REQ-008 SHALL have port Decode, output, CNT_W, last measured high time in CLK cycles.
REQ-009 SHALL have port VALID, output, 1, one-cycle pulse when Period/Decode are updated by a completed measurement.
REQ-010 SHALL have port TMO, output, 1, sticky stuck-input flag.
REQ-011 SHALL have port LEVEL, output, 1, synchronized PWM_IN level.

Function
REQ-012 SHALL pass PWM_IN through two flops (s1, s2) plus one history flop (s3); rise = s2 & ~s3; LEVEL = s2.
REQ-013 SHALL implement an FSM with states IDLE and MEASURE.
REQ-014 In IDLE, a rise SHALL set period_cnt=1 and high_cnt=1 and move to MEASURE; no VALID is produced (first edge only arms).
REQ-015 In MEASURE without rise: period_cnt +1; high_cnt +1 when s2=1; both counters saturate at 2^CNT_W-1 and never wrap.
REQ-016 In MEASURE on rise: Period<=period_cnt, Decode<=high_cnt, VALID=1 for that one cycle, TMO<=0, and both counters reload to 1.
REQ-017 For a steady waveform with H cycles high and L cycles low, every VALID SHALL report Period=H+L and Decode=H exactly.
REQ-018 Latency: if PWM_IN is first sampled high at CLK edge k, Period/Decode/VALID SHALL be updated at edge k+2 (2-cycle synchronizer latency; rise is combinational on s2/s3).
REQ-019 In MEASURE, when period_cnt reaches TIMEOUT with no rise: go to IDLE, Period<=0, Decode<=0, TMO<=1, VALID stays 0.
REQ-020 If a rise and the timeout condition occur in the same cycle, the rise SHALL win (REQ-016 applies).
REQ-021 If EN=0: go to IDLE, clear both counters, and ignore rise events; Period, Decode and TMO hold their values and VALID=0.
REQ-022 Deasserting EN mid-measurement SHALL discard the partial measurement; after EN returns to 1, the first rise only arms the measurement.
REQ-023 A high pulse 1 cycle wide SHALL be measurable: for H=1, L=1 the block reports Period=2, Decode=1.
REQ-024 Pulses shorter than one CLK period may be missed; this SHALL NOT corrupt the FSM.

Reset
REQ-025 When RST_N=0 at a CLK edge, the following SHALL hold after that edge: s1=s2=s3=0, state IDLE, counters 0, Period=0, Decode=0, VALID=0, TMO=0, LEVEL=0.
REQ-026 Reset SHALL take priority over EN and PWM_IN; asserting it mid-measurement discards all state.
REQ-027 After reset release, the first rise SHALL only arm the measurement (REQ-014).

Verification
REQ-028 EN=1, PWM H=3/L=7 cycles, 4 periods -> 3 VALID pulses, each with Period=10, Decode=3; VALID at edge k+2 after each rise sampled at k.
REQ-029 H=1/L=1 -> Period=2, Decode=1; then H=7/L=0 (PWM_IN held high) with TIMEOUT=20 -> after 20 cycles from the last rise: Period=0, Decode=0, TMO=1, state IDLE.
REQ-030 After the TMO case, resume H=5/L=5 -> first rise gives no VALID, second rise gives Period=10, Decode=5, TMO=0.
REQ-031 EN driven low for 3 cycles in the middle of a 10-cycle period -> no VALID for that period; Period/Decode keep their old values; the next valid report follows arm-then-measure.
REQ-032 RST_N=0 for 1 cycle in the middle of a measurement -> all outputs 0 next cycle; the first post-reset rise produces no VALID.
REQ-033 With CNT_W=4 and TIMEOUT=15, an 18-cycle period -> timeout fires; period_cnt never wraps past 15.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronizes PWM_IN, measures rising-edge-to-rising-edge
// period and high time in CLK cycles, and flags a stuck input after TIMEOUT cycles.
module pwm_capture #(
    parameter int              CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = 28'd50_000_000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] Decode,
    output logic             VALID,
    output logic             TMO,
    output logic             LEVEL
);

    localparam logic [0:0] STATE_IDLE    = 1'b0;
    localparam logic [0:0] STATE_MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1, s2, s3;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PWM_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise  = s2 & ~s3;
    assign LEVEL = s2;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= STATE_IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            Period     <= '0;
            Decode     <= '0;
            VALID      <= 1'b0;
            TMO        <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (!EN) begin
                state      <= STATE_IDLE;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else begin
                case (state)
                    STATE_IDLE: begin
                        // The first edge after idle only arms; there is no full period yet
                        if (rise) begin
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                            state      <= STATE_MEASURE;
                        end
                    end
                    STATE_MEASURE: begin
                        // A rise outranks a timeout landing on the same cycle
                        if (rise) begin
                            Period     <= period_cnt;
                            Decode     <= high_cnt;
                            VALID      <= 1'b1;
                            TMO        <= 1'b0;
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                        end else if (period_cnt >= TIMEOUT) begin
                            state      <= STATE_IDLE;
                            Period     <= '0;
                            Decode     <= '0;
                            TMO        <= 1'b1;
                            period_cnt <= '0;
                            high_cnt   <= '0;
                        end else begin
                            if (period_cnt != CNT_MAX) begin
                                period_cnt <= period_cnt + CNT_ONE;
                            end
                            if (s2 && (high_cnt != CNT_MAX)) begin
                                high_cnt <= high_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: state <= STATE_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a wide instance with a short timeout and a 4-bit
// instance for the narrow-counter timeout case.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_b, pwm_b, en_s, pwm_s;
    logic [27:0] period_b, decode_b;
    logic [3:0]  period_s, decode_s;
    logic        valid_b, tmo_b, level_b, valid_s, tmo_s, level_s;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          h;
        int          l;
        int          nper;
        logic [27:0] period;
        logic [27:0] decode;
    } vec_t;

    vec_t vecs[5];

    pwm_capture #(.CNT_W(28), .TIMEOUT(28'd20)) dut_b (
        .CLK(clk), .RST_N(rst_n), .EN(en_b), .PWM_IN(pwm_b),
        .Period(period_b), .Decode(decode_b), .VALID(valid_b), .TMO(tmo_b), .LEVEL(level_b)
    );

    pwm_capture #(.CNT_W(4), .TIMEOUT(4'd15)) dut_s (
        .CLK(clk), .RST_N(rst_n), .EN(en_s), .PWM_IN(pwm_s),
        .Period(period_s), .Decode(decode_s), .VALID(valid_s), .TMO(tmo_s), .LEVEL(level_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drivePwm(input bit sel, input logic v);
        if (sel) pwm_s = v;
        else     pwm_b = v;
    endtask

    // Drives nper periods of h high / l low cycles plus a short low tail, and
    // checks every VALID report and the total number of reports.
    task automatic applyStimulus(input bit sel, input int h, input int l, input int nper,
                                 input logic [27:0] ep, input logic [27:0] ed, input int ev);
        int nv;
        logic v;
        logic [27:0] p, d;
        nv = 0;
        for (int k = 0; k < nper * (h + l) + 3; k++) begin
            drivePwm(sel, (k < nper * (h + l)) && ((k % (h + l)) < h));
            tick();
            v = sel ? valid_s : valid_b;
            p = sel ? 28'(period_s) : period_b;
            d = sel ? 28'(decode_s) : decode_b;
            if (v) begin
                nv++;
                checkOutput("period", p, ep);
                checkOutput("decode", d, ed);
            end
        end
        checkOutput("valid_count", 28'(nv), 28'(ev));
    endtask

    initial begin
        vecs[0] = '{h: 3, l: 7, nper: 4, period: 28'd10, decode: 28'd3};
        vecs[1] = '{h: 1, l: 1, nper: 4, period: 28'd2,  decode: 28'd1};
        vecs[2] = '{h: 5, l: 5, nper: 3, period: 28'd10, decode: 28'd5};
        vecs[3] = '{h: 2, l: 9, nper: 3, period: 28'd11, decode: 28'd2};
        vecs[4] = '{h: 6, l: 1, nper: 3, period: 28'd7,  decode: 28'd6};

        rst_n = 1'b0; en_b = 1'b1; en_s = 1'b1; pwm_b = 1'b1; pwm_s = 1'b1;
        tick();
        tick();
        checkOutput("rst_period", period_b, 28'd0);
        checkOutput("rst_decode", decode_b, 28'd0);
        checkOutput("rst_valid", 28'(valid_b), 28'd0);
        checkOutput("rst_tmo", 28'(tmo_b), 28'd0);
        checkOutput("rst_level", 28'(level_b), 28'd0);
        pwm_b = 1'b0; pwm_s = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 5; i++) begin
            en_b = 1'b0;
            tick();
            en_b = 1'b1;
            tick();
            applyStimulus(1'b0, vecs[i].h, vecs[i].l, vecs[i].nper,
                          vecs[i].period, vecs[i].decode, vecs[i].nper - 1);
        end

        // Rise sampled at edge k reports at edge k+2 while measuring
        pwm_b = 1'b1;
        tick();
        checkOutput("lat_valid_k", 28'(valid_b), 28'd0);
        checkOutput("lat_level_k", 28'(level_b), 28'd0);
        tick();
        checkOutput("lat_valid_k1", 28'(valid_b), 28'd0);
        checkOutput("lat_level_k1", 28'(level_b), 28'd1);
        tick();
        checkOutput("lat_valid_k2", 28'(valid_b), 28'd1);
        pwm_b = 1'b0;
        repeat (3) tick();
        en_b = 1'b0;
        tick();
        en_b = 1'b1;
        tick();

        // H=1/L=1 then held high until timeout
        pwm_b = 1'b1; tick();
        pwm_b = 1'b0; tick();
        pwm_b = 1'b1; tick();
        tick();
        tick();
        checkOutput("tmo_pre_valid", 28'(valid_b), 28'd1);
        checkOutput("tmo_pre_period", period_b, 28'd2);
        checkOutput("tmo_pre_decode", decode_b, 28'd1);
        for (int i = 0; i < 19; i++) begin
            tick();
            checkOutput("tmo_hold_valid", 28'(valid_b), 28'd0);
        end
        checkOutput("tmo_before", 28'(tmo_b), 28'd0);
        checkOutput("tmo_before_period", period_b, 28'd2);
        tick();
        checkOutput("tmo_set", 28'(tmo_b), 28'd1);
        checkOutput("tmo_period", period_b, 28'd0);
        checkOutput("tmo_decode", decode_b, 28'd0);
        checkOutput("tmo_valid", 28'(valid_b), 28'd0);

        pwm_b = 1'b0;
        repeat (5) tick();
        checkOutput("tmo_sticky", 28'(tmo_b), 28'd1);
        applyStimulus(1'b0, 5, 5, 2, 28'd10, 28'd5, 1);
        checkOutput("tmo_cleared", 28'(tmo_b), 28'd0);

        // EN low mid-measurement discards the partial period
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("en_valid", 28'(valid_b), 28'd0);
        end
        checkOutput("en_period_hold", period_b, 28'd10);
        checkOutput("en_decode_hold", decode_b, 28'd5);
        en_b = 1'b1;
        repeat (2) tick();
        applyStimulus(1'b0, 2, 8, 2, 28'd10, 28'd2, 1);

        // Reset mid-measurement
        pwm_b = 1'b1;
        rst_n = 1'b0;
        tick();
        checkOutput("mrst_period", period_b, 28'd0);
        checkOutput("mrst_decode", decode_b, 28'd0);
        checkOutput("mrst_valid", 28'(valid_b), 28'd0);
        checkOutput("mrst_tmo", 28'(tmo_b), 28'd0);
        checkOutput("mrst_level", 28'(level_b), 28'd0);
        rst_n = 1'b1;
        pwm_b = 1'b0;
        repeat (3) tick();
        applyStimulus(1'b0, 3, 7, 2, 28'd10, 28'd3, 1);

        // Narrow counters: a normal period, then an 18-cycle period that times out
        applyStimulus(1'b1, 2, 8, 2, 28'd10, 28'd2, 1);
        en_s = 1'b0;
        tick();
        en_s = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) begin
            pwm_s = (i <= 2) || (i >= 19);
            tick();
            checkOutput("small_valid", 28'(valid_s), 28'd0);
            checkOutput("small_tmo", 28'(tmo_s), (i >= 18) ? 28'd1 : 28'd0);
            if (i == 17) checkOutput("small_period_pre", 28'(period_s), 28'd10);
            if (i == 18) checkOutput("small_period_tmo", 28'(period_s), 28'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
